// File: rtl/mio_bus_arbiter_pkg.sv
// Shared encodings and defaults for the MIO bus arbiter.
// Both pipeline requesters and the arbiter use these.
package mio_bus_arbiter_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ACC  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

endpackage

// File: rtl/mio_bus_arbiter_if.sv
// Bundle of IF/MEM requester handshakes and the MIO bus signals.
// The master modport is the arbiter's view; slave is the CPU/bus side.
interface mio_bus_arbiter_if
  import mio_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              mio_req;
  logic              mio_we;
  logic [ADDR_W-1:0] mio_addr;
  logic [DATA_W-1:0] mio_wdata;
  logic [DATA_W-1:0] mio_rdata;
  logic              MIO_ready;
  logic              stall_if;
  logic              stall_mem;
  logic              bus_err;

  modport master (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mio_rdata, MIO_ready,
    output if_rdata, if_done, mem_rdata, mem_done, mio_req, mio_we, mio_addr, mio_wdata,
           stall_if, stall_mem, bus_err
  );

  modport slave (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mio_rdata, MIO_ready,
    input  if_rdata, if_done, mem_rdata, mem_done, mio_req, mio_we, mio_addr, mio_wdata,
           stall_if, stall_mem, bus_err
  );
endinterface

// File: rtl/mio_bus_arbiter_wdog.sv
// Access watchdog: counts MIO wait cycles and flags the TIMEOUT-th ACC cycle.
// TIMEOUT=0 disables it; the count saturates so it never wraps.
module mio_bus_arbiter_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] LAST = LAST_I[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter value equals the number of ACC cycles already spent waiting.
  assign expired = (TIMEOUT != 0) && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired && (TIMEOUT != 0)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mio_bus_arbiter.sv
// Shares the MIO bus between IF fetches and MEM loads/stores (MEM first),
// drives the registered MIO handshake and returns data, done and stalls.
module mio_bus_arbiter
  import mio_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  mio_bus_arbiter_if.master bus
);
  arb_state_e        state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic              mio_req_q, mio_req_d;
  logic              mio_we_q, mio_we_d;
  logic [ADDR_W-1:0] mio_addr_q, mio_addr_d;
  logic [DATA_W-1:0] mio_wdata_q, mio_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic              bus_err_q, bus_err_d;
  logic              wd_clr, wd_en, wd_expired;

  mio_bus_arbiter_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    mio_req_d   = mio_req_q;
    mio_we_d    = mio_we_q;
    mio_addr_d  = mio_addr_q;
    mio_wdata_d = mio_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    bus_err_d   = 1'b0;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // MEM wins: its instruction is older than the one being fetched.
        if (bus.mem_req) begin
          gnt_d       = GNT_MEM;
          mio_req_d   = 1'b1;
          mio_we_d    = bus.mem_we;
          mio_addr_d  = bus.mem_addr;
          mio_wdata_d = bus.mem_wdata;
          wd_clr      = 1'b1;
          state_d     = ARB_ACC;
        end else if (bus.if_req) begin
          gnt_d       = GNT_IF;
          mio_req_d   = 1'b1;
          mio_we_d    = 1'b0;
          mio_addr_d  = bus.if_addr;
          mio_wdata_d = '0;
          wd_clr      = 1'b1;
          state_d     = ARB_ACC;
        end
      end
      ARB_ACC: begin
        if (bus.MIO_ready) begin
          mio_req_d = 1'b0;
          state_d   = ARB_RESP;
          if (gnt_q == GNT_MEM) begin
            mem_rdata_d = bus.mio_rdata;
            mem_done_d  = 1'b1;
          end else begin
            if_rdata_d = bus.mio_rdata;
            if_done_d  = 1'b1;
          end
        end else if (wd_expired) begin
          mio_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = ARB_RESP;
          if (gnt_q == GNT_MEM) begin
            mem_rdata_d = '0;
            mem_done_d  = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_done_d  = 1'b1;
          end
        end else begin
          wd_en = 1'b1;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= GNT_IF;
      mio_req_q   <= 1'b0;
      mio_we_q    <= 1'b0;
      mio_addr_q  <= '0;
      mio_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mio_req_q   <= mio_req_d;
      mio_we_q    <= mio_we_d;
      mio_addr_q  <= mio_addr_d;
      mio_wdata_q <= mio_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.mio_req   = mio_req_q;
  assign bus.mio_we    = mio_we_q;
  assign bus.mio_addr  = mio_addr_q;
  assign bus.mio_wdata = mio_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall_if  = bus.if_req && !if_done_q;
  assign bus.stall_mem = bus.mem_req && !mem_done_q;
endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: one default-timeout instance and one
// with TIMEOUT=4 for the watchdog abort path.
module tb_mio_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mio_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  mio_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    bus0.if_req = 0; bus0.if_addr = 0; bus0.mem_req = 0; bus0.mem_we = 0;
    bus0.mem_addr = 0; bus0.mem_wdata = 0; bus0.mio_rdata = 0; bus0.MIO_ready = 0;
    bus1.if_req = 0; bus1.if_addr = 0; bus1.mem_req = 0; bus1.mem_we = 0;
    bus1.mem_addr = 0; bus1.mem_wdata = 0; bus1.mio_rdata = 0; bus1.MIO_ready = 0;

    // Reset state
    tick(); tick();
    chk("rst_mio_req", bus0.mio_req, 0);
    chk("rst_mio_addr", bus0.mio_addr, 0);
    chk("rst_if_done", bus0.if_done, 0);
    chk("rst_mem_done", bus0.mem_done, 0);
    chk("rst_bus_err", bus0.bus_err, 0);
    chk("rst_if_rdata", bus0.if_rdata, 0);
    chk("rst_mem_rdata", bus0.mem_rdata, 0);
    chk("rst1_mio_req", bus1.mio_req, 0);
    rst = 0;
    tick();

    // Single IF fetch, ready one cycle after mio_req
    bus0.if_req = 1; bus0.if_addr = 32'h0000_0004;
    #1;
    chk("t1_stall_if_c0", bus0.stall_if, 1);
    tick();
    chk("t1_mio_req_c1", bus0.mio_req, 1);
    chk("t1_mio_addr_c1", bus0.mio_addr, 32'h4);
    chk("t1_mio_we_c1", bus0.mio_we, 0);
    chk("t1_stall_if_c1", bus0.stall_if, 1);
    chk("t1_if_done_c1", bus0.if_done, 0);
    bus0.MIO_ready = 1; bus0.mio_rdata = 32'h2008_0005;
    tick();
    chk("t1_if_done_c2", bus0.if_done, 1);
    chk("t1_if_rdata_c2", bus0.if_rdata, 32'h2008_0005);
    chk("t1_mio_req_c2", bus0.mio_req, 0);
    chk("t1_stall_if_c2", bus0.stall_if, 0);
    chk("t1_bus_err_c2", bus0.bus_err, 0);
    bus0.if_req = 0; bus0.MIO_ready = 0;
    tick();
    chk("t1_if_done_c3", bus0.if_done, 0);

    // Simultaneous store and fetch: store first
    bus0.mem_req = 1; bus0.mem_we = 1; bus0.mem_addr = 32'h10; bus0.mem_wdata = 32'hDEAD_BEEF;
    bus0.if_req = 1; bus0.if_addr = 32'h8;
    tick();
    chk("t2_mio_req_s", bus0.mio_req, 1);
    chk("t2_mio_we_s", bus0.mio_we, 1);
    chk("t2_mio_addr_s", bus0.mio_addr, 32'h10);
    chk("t2_mio_wdata_s", bus0.mio_wdata, 32'hDEAD_BEEF);
    chk("t2_stall_if_s", bus0.stall_if, 1);
    bus0.MIO_ready = 1; bus0.mio_rdata = 32'h0000_1234;
    tick();
    chk("t2_mem_done", bus0.mem_done, 1);
    chk("t2_if_done_early", bus0.if_done, 0);
    chk("t2_stall_mem", bus0.stall_mem, 0);
    chk("t2_stall_if_held", bus0.stall_if, 1);
    bus0.mem_req = 0; bus0.MIO_ready = 0;
    tick();
    chk("t2_mem_done_once", bus0.mem_done, 0);
    chk("t2_mio_req_idle", bus0.mio_req, 0);
    tick();
    chk("t2_mio_req_f", bus0.mio_req, 1);
    chk("t2_mio_addr_f", bus0.mio_addr, 32'h8);
    chk("t2_mio_we_f", bus0.mio_we, 0);
    chk("t2_mio_wdata_f", bus0.mio_wdata, 0);
    bus0.MIO_ready = 1; bus0.mio_rdata = 32'hAAAA_5555;
    tick();
    chk("t2_if_done", bus0.if_done, 1);
    chk("t2_mem_done_none", bus0.mem_done, 0);
    chk("t2_if_rdata", bus0.if_rdata, 32'hAAAA_5555);
    bus0.if_req = 0; bus0.MIO_ready = 0;
    tick();
    chk("t2_if_done_once", bus0.if_done, 0);

    // Load with five wait cycles
    bus0.mem_req = 1; bus0.mem_we = 0; bus0.mem_addr = 32'h20; bus0.mem_wdata = 0;
    bus0.mio_rdata = 32'h1111_1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_mio_req_wait", bus0.mio_req, 1);
      chk("t3_mio_addr_wait", bus0.mio_addr, 32'h20);
      chk("t3_mem_done_wait", bus0.mem_done, 0);
      tick();
    end
    chk("t3_mio_req_last", bus0.mio_req, 1);
    chk("t3_mio_addr_last", bus0.mio_addr, 32'h20);
    bus0.MIO_ready = 1; bus0.mio_rdata = 32'hCAFE_F00D;
    tick();
    chk("t3_mem_done", bus0.mem_done, 1);
    chk("t3_mem_rdata", bus0.mem_rdata, 32'hCAFE_F00D);
    chk("t3_mio_req_drop", bus0.mio_req, 0);
    chk("t3_bus_err", bus0.bus_err, 0);
    bus0.mem_req = 0; bus0.MIO_ready = 0;
    tick();
    chk("t3_mem_done_once", bus0.mem_done, 0);

    // TIMEOUT=4 instance: a good load first, then an aborted one
    bus1.mem_req = 1; bus1.mem_we = 0; bus1.mem_addr = 32'h40;
    tick();
    bus1.MIO_ready = 1; bus1.mio_rdata = 32'h5A5A_5A5A;
    tick();
    chk("t4_ok_mem_done", bus1.mem_done, 1);
    chk("t4_ok_mem_rdata", bus1.mem_rdata, 32'h5A5A_5A5A);
    chk("t4_ok_bus_err", bus1.bus_err, 0);
    bus1.mem_req = 0; bus1.MIO_ready = 0; bus1.mio_rdata = 32'h7777_7777;
    tick();
    bus1.mem_req = 1; bus1.mem_addr = 32'h44;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t4_mio_req_acc", bus1.mio_req, 1);
      chk("t4_mem_done_acc", bus1.mem_done, 0);
      chk("t4_bus_err_acc", bus1.bus_err, 0);
      tick();
    end
    chk("t4_mio_req_abort", bus1.mio_req, 0);
    chk("t4_mem_done_abort", bus1.mem_done, 1);
    chk("t4_bus_err_abort", bus1.bus_err, 1);
    chk("t4_mem_rdata_abort", bus1.mem_rdata, 0);
    bus1.mem_req = 0;
    tick();
    chk("t4_mem_done_after", bus1.mem_done, 0);
    chk("t4_bus_err_after", bus1.bus_err, 0);

    // Reset during the second ACC cycle abandons the access
    bus0.if_req = 1; bus0.if_addr = 32'h100;
    tick();
    tick();
    chk("t5_mio_req_acc2", bus0.mio_req, 1);
    rst = 1; bus0.MIO_ready = 1; bus0.mio_rdata = 32'h9999_9999;
    tick();
    chk("t5_mio_req_rst", bus0.mio_req, 0);
    chk("t5_if_done_rst", bus0.if_done, 0);
    chk("t5_mem_done_rst", bus0.mem_done, 0);
    chk("t5_bus_err_rst", bus0.bus_err, 0);
    chk("t5_if_rdata_rst", bus0.if_rdata, 0);
    rst = 0; bus0.MIO_ready = 0;
    tick();
    chk("t5_mio_req_regrant", bus0.mio_req, 1);
    chk("t5_mio_addr_regrant", bus0.mio_addr, 32'h100);
    bus0.MIO_ready = 1; bus0.mio_rdata = 32'h0BAD_0BAD;
    tick();
    chk("t5_if_done", bus0.if_done, 1);
    chk("t5_if_rdata", bus0.if_rdata, 32'h0BAD_0BAD);
    bus0.if_req = 0; bus0.MIO_ready = 0;
    tick();

    // MIO_ready while idle is ignored
    bus0.MIO_ready = 1; bus0.mio_rdata = 32'hFFFF_FFFF;
    tick();
    chk("t6_if_done", bus0.if_done, 0);
    chk("t6_mem_done", bus0.mem_done, 0);
    chk("t6_mio_req", bus0.mio_req, 0);
    chk("t6_if_rdata_hold", bus0.if_rdata, 32'h0BAD_0BAD);
    chk("t6_mem_rdata_hold", bus0.mem_rdata, 0);
    bus0.MIO_ready = 0;
    tick();
    chk("t6_if_done_2", bus0.if_done, 0);
    bus0.if_req = 1; bus0.if_addr = 32'h200;
    tick();
    chk("t6_mio_req_grant", bus0.mio_req, 1);
    chk("t6_mio_addr_grant", bus0.mio_addr, 32'h200);
    bus0.MIO_ready = 1; bus0.mio_rdata = 32'h1357_9BDF;
    tick();
    chk("t6_if_done_grant", bus0.if_done, 1);
    chk("t6_if_rdata_grant", bus0.if_rdata, 32'h1357_9BDF);
    bus0.if_req = 0; bus0.MIO_ready = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
